// File: rtl/sim_run_pkg.sv
// Shared types and constants for the simulation run controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sim_run_pkg;

  // Run phases: core held in reset, executing, pipeline emptying after halt, finished.
  typedef enum logic [1:0] {
    RESET_HOLD,
    RUN,
    DRAIN,
    DONE
  } run_state_t;

  // MIPS "beq $0,$0,-1": branch-to-self, the program's end-of-test idiom.
  localparam logic [31:0] MIPS_SELF_LOOP = 32'h1000FFFF;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Latency: count reflects clr/en on the following rising edge.
// Backpressure: none; holds at all-ones instead of wrapping.
// Ports: clk, rst (async, active-high), clr (sync clear, wins over en), en, count.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/sim_run_ctrl.sv
// Run controller for processor sims: sequences core reset, counts cycles and retires, ends on halt/budget/stall.
// Latency: outputs registered; done rises DRAIN_CYCLES+1 edges after the halt retire is sampled.
// Backpressure: none; the wb_* retire stream is observed only, never stalled.
// Ports: clk, rst (async, active-high); wb_valid/wb_instr (retire stream in);
//        core_rst, cycle_count, retired_count, done, pass, timeout, stall (all registered).
// Option: define SIM_RUN_CTRL_STALL_WDOG_EN to enable the no-retire watchdog (stall).
module sim_run_ctrl
  import sim_run_pkg::*;
#(
  parameter int          RST_CYCLES   = 4,
  parameter int          MAX_CYCLES   = 2500,
  parameter int          DRAIN_CYCLES = 5,
  parameter logic [31:0] HALT_INSTR   = MIPS_SELF_LOOP,
  parameter int          CNT_W        = 32,
  parameter int          STALL_LIMIT  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_valid,
  input  logic [31:0]      wb_instr,
  output logic             core_rst,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retired_count,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic             stall
);

  // core_rst is 1 straight out of reset and can only change on an edge, so
  // RST_CYCLES of 0 and 1 both release the core on the first edge.
  localparam int HOLD_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int HOLD_LAST = (RST_CYCLES > 1) ? RST_CYCLES - 1 : 0;
  localparam int DRAIN_W   = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  // If MAX_CYCLES does not fit in CNT_W the counter saturates first and the
  // budget can never be reached; truncating the compare would fire early.
  localparam bit TMO_REACHABLE = ($clog2(MAX_CYCLES + 1) <= CNT_W);

  run_state_t          state, state_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
  logic [DRAIN_W-1:0]  drain_cnt, drain_nxt;
  logic                core_rst_nxt, done_nxt, pass_nxt, timeout_nxt, stall_nxt;
  logic                active, is_halt, budget_hit, idle_hit;

  assign active  = (state == RUN) || (state == DRAIN);
  assign is_halt = wb_valid && (wb_instr == HALT_INSTR);
  // Matches on the edge whose increment lands cycle_count on MAX_CYCLES.
  assign budget_hit = TMO_REACHABLE && (cycle_count == CNT_W'(MAX_CYCLES - 1));

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .en    (active),
    .count (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_retired_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .en    (active && wb_valid),
    .count (retired_count)
  );

`ifdef SIM_RUN_CTRL_STALL_WDOG_EN
  localparam int IDLE_W = $clog2(STALL_LIMIT + 1);
  logic [IDLE_W-1:0] idle_count;

  // Cycles since the last retire, tracked only while running.
  sat_counter #(.W(IDLE_W)) u_idle_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   ((state == RUN) && wb_valid),
    .en    (state == RUN),
    .count (idle_count)
  );

  assign idle_hit = !wb_valid && (idle_count == IDLE_W'(STALL_LIMIT - 1));
`else
  // No watchdog: stall can never be set and stays tied low.
  assign idle_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RESET_HOLD;
      hold_cnt  <= '0;
      drain_cnt <= '0;
      core_rst  <= 1'b1;
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      stall     <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      drain_cnt <= drain_nxt;
      core_rst  <= core_rst_nxt;
      done      <= done_nxt;
      pass      <= pass_nxt;
      timeout   <= timeout_nxt;
      stall     <= stall_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    hold_nxt     = hold_cnt;
    drain_nxt    = drain_cnt;
    core_rst_nxt = core_rst;
    done_nxt     = done;
    pass_nxt     = pass;
    timeout_nxt  = timeout;
    stall_nxt    = stall;
    case (state)
      RESET_HOLD: begin
        if (hold_cnt == HOLD_W'(HOLD_LAST)) begin
          state_nxt    = RUN;
          core_rst_nxt = 1'b0;
        end else begin
          hold_nxt = hold_cnt + HOLD_W'(1);
        end
      end
      RUN: begin
        // Priority: halt, then cycle budget, then watchdog.
        if (is_halt) begin
          state_nxt = DRAIN;
          drain_nxt = DRAIN_W'(DRAIN_CYCLES);
        end else if (budget_hit) begin
          state_nxt   = DONE;
          done_nxt    = 1'b1;
          timeout_nxt = 1'b1;
        end else if (idle_hit) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
          stall_nxt = 1'b1;
        end
      end
      DRAIN: begin
        // Loaded with DRAIN_CYCLES on the halt edge; DONE on the edge that sees 0.
        if (drain_cnt == '0) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
          pass_nxt  = 1'b1;
        end else begin
          drain_nxt = drain_cnt - DRAIN_W'(1);
        end
      end
      default: begin
        // DONE: everything holds until rst.
      end
    endcase
  end

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Bench for sim_run_ctrl: two instances (32-bit counters, and 4-bit counters whose
// budget cannot be reached) share one randomised retire stream; a reference model
// predicts each run's events, which a monitor pops and compares as they appear.
module tb_sim_run_ctrl;

  localparam int          RSTC = 4;
  localparam int          DRN  = 5;
  localparam int          MAX0 = 100;
  localparam int          MAX1 = 20;
  localparam int          LIM  = 8;
  localparam int          WIN  = 130;
  localparam int          GEN  = 110;
  localparam logic [31:0] HALT = 32'h1000FFFF;
`ifdef SIM_RUN_CTRL_STALL_WDOG_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_valid = 1'b0;
  logic [31:0] wb_instr = '0;

  logic        core0, done0, pass0, tmo0, stall0;
  logic [31:0] cyc0, ret0;
  logic        core1, done1, pass1, tmo1, stall1;
  logic [3:0]  cyc1, ret1;

  always #5 clk = ~clk;

  sim_run_ctrl #(
    .RST_CYCLES(RSTC), .MAX_CYCLES(MAX0), .DRAIN_CYCLES(DRN),
    .HALT_INSTR(HALT), .CNT_W(32), .STALL_LIMIT(LIM)
  ) u_main (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_instr(wb_instr),
    .core_rst(core0), .cycle_count(cyc0), .retired_count(ret0),
    .done(done0), .pass(pass0), .timeout(tmo0), .stall(stall0)
  );

  sim_run_ctrl #(
    .RST_CYCLES(RSTC), .MAX_CYCLES(MAX1), .DRAIN_CYCLES(DRN),
    .HALT_INSTR(HALT), .CNT_W(4), .STALL_LIMIT(LIM)
  ) u_sat (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_instr(wb_instr),
    .core_rst(core1), .cycle_count(cyc1), .retired_count(ret1),
    .done(done1), .pass(pass1), .timeout(tmo1), .stall(stall1)
  );

  // kind 0: core_rst falls; kind 1: done rises.
  typedef struct {
    int     kind;
    int     edge_no;
    longint cyc;
    longint ret;
    bit     d, p, t, s;
  } ev_t;

  typedef struct {
    bit     fin;
    int     end_n;
    bit     p, t, s;
    longint cyc;
    longint ret;
  } res_t;

  ev_t         q0[$];
  ev_t         q1[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          edge_n = 0;
  bit          pr_core [2];
  bit          pr_done [2];
  bit          st_v [0:WIN];
  logic [31:0] st_i [0:WIN];

  // Rising edges since rst last deasserted.
  always @(posedge clk or posedge rst) begin
    if (rst) edge_n <= 0;
    else     edge_n <= edge_n + 1;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Walks the run cycle by cycle from the rules: retire count, first halt,
  // budget, gap since last retire; result saturated to the counter width.
  function automatic res_t model(input int max_c, input int cnt_w);
    res_t   r;
    int     halt_at = 0;
    int     last_ret = 0;
    longint cap = (longint'(1) << cnt_w) - 1;
    r.fin = 1'b0; r.end_n = 0; r.p = 1'b0; r.t = 1'b0; r.s = 1'b0; r.cyc = 0; r.ret = 0;
    for (int n = 1; n <= WIN && !r.fin; n++) begin
      r.cyc = n;
      if (st_v[n]) begin
        r.ret++;
        last_ret = n;
      end
      if (halt_at == 0) begin
        if (st_v[n] && st_i[n] == HALT) halt_at = n;
        else if (max_c <= cap && n == max_c) r.t = 1'b1;
        else if (WDOG && (n - last_ret) == LIM) r.s = 1'b1;
      end
      if (halt_at != 0 && n == halt_at + DRN + 1) r.p = 1'b1;
      if (r.p || r.t || r.s) begin
        r.fin   = 1'b1;
        r.end_n = n;
      end
    end
    if (r.cyc > cap) r.cyc = cap;
    if (r.ret > cap) r.ret = cap;
    return r;
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] x;
    x = $urandom;
    if (x == HALT) x = x ^ 32'h1;
    return x;
  endfunction

  // Mode 0: odd-cycle retires then halt at h; 1: random with halt at h (plus
  // ignored later halts); 2: random, no halt; 3: random, halt at h; 4: retires
  // stop after cycle 30; 5: retire every cycle up to halt at h.
  task automatic gen(input int mode, input int h);
    for (int n = 0; n <= WIN; n++) begin
      st_v[n] = 1'b0;
      st_i[n] = ($urandom_range(0, 3) == 0) ? HALT : rnd_instr();
      if (n >= 1 && n <= GEN) begin
        case (mode)
          0:       st_v[n] = (n <= 19) ? n[0] : (n == h);
          1:       st_v[n] = (n == h) || ($urandom_range(0, 3) != 0);
          2:       st_v[n] = ($urandom_range(0, 7) != 0);
          3:       st_v[n] = (n == h) || ($urandom_range(0, 7) != 0);
          4:       st_v[n] = (n <= 30);
          default: st_v[n] = (n <= h);
        endcase
        if (st_v[n]) st_i[n] = rnd_instr();
        if (n == h) st_i[n] = HALT;
        if (mode == 1 && n > h && st_v[n] && $urandom_range(0, 7) == 0) st_i[n] = HALT;
      end
    end
  endtask

  task automatic mon(input int i, input logic c, input logic d, input logic p,
                     input logic t, input logic s, input longint cyc, input longint ret);
    ev_t e;
    bit  have;
    if (rst) begin
      pr_core[i] = 1'b1;
      pr_done[i] = 1'b0;
      return;
    end
    if ((pr_core[i] && !c) || (!pr_done[i] && d)) begin
      have = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
      if (!have) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_event inst%0d: got event at edge %0d, expected none", i, edge_n);
      end else begin
        if (i == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        chk($sformatf("inst%0d_ev_kind", i), (pr_core[i] && !c) ? 0 : 1, e.kind);
        chk($sformatf("inst%0d_ev_edge", i), edge_n, e.edge_no);
        chk($sformatf("inst%0d_ev_cycle_count", i), cyc, e.cyc);
        chk($sformatf("inst%0d_ev_retired_count", i), ret, e.ret);
        chk($sformatf("inst%0d_ev_done", i), d, e.d);
        chk($sformatf("inst%0d_ev_pass", i), p, e.p);
        chk($sformatf("inst%0d_ev_timeout", i), t, e.t);
        chk($sformatf("inst%0d_ev_stall", i), s, e.s);
      end
    end
    pr_core[i] = c;
    pr_done[i] = d;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_core_rst"}, core0, 1);
    chk({tag, "_done"}, done0, 0);
    chk({tag, "_flags"}, {pass0, tmo0, stall0}, 0);
    chk({tag, "_cycle_count"}, cyc0, 0);
    chk({tag, "_retired_count"}, ret0, 0);
    chk({tag, "_sat_core_rst"}, core1, 1);
    chk({tag, "_sat_state"}, {done1, pass1, tmo1, stall1, cyc1, ret1}, 0);
  endtask

  task automatic run(input int mode, input int h);
    res_t m0, m1;
    ev_t  e;
    int   n;
    gen(mode, h);
    m0 = model(MAX0, 32);
    m1 = model(MAX1, 4);
    @(negedge clk);
    rst      = 1'b1;
    wb_valid = 1'b0;
    #1;
    chk_reset_vals("in_reset");
    repeat (3) @(negedge clk);
    e = '{kind: 0, edge_no: RSTC, cyc: 0, ret: 0, d: 1'b0, p: 1'b0, t: 1'b0, s: 1'b0};
    q0.push_back(e);
    q1.push_back(e);
    if (mode != 5) begin
      if (m0.fin) begin
        e = '{kind: 1, edge_no: RSTC + m0.end_n, cyc: m0.cyc, ret: m0.ret,
              d: 1'b1, p: m0.p, t: m0.t, s: m0.s};
        q0.push_back(e);
      end
      if (m1.fin) begin
        e = '{kind: 1, edge_no: RSTC + m1.end_n, cyc: m1.cyc, ret: m1.ret,
              d: 1'b1, p: m1.p, t: m1.t, s: m1.s};
        q1.push_back(e);
      end
    end
    rst = 1'b0;
    for (int ei = 1; ei <= RSTC + WIN; ei++) begin
      n = ei - RSTC;
      if (n < 1) begin
        // Reset-hold: halts here must be ignored.
        wb_valid = ($urandom_range(0, 1) == 1);
        wb_instr = HALT;
      end else begin
        wb_valid = st_v[n];
        wb_instr = st_i[n];
      end
      @(negedge clk);
      if (n < 0) begin
        chk("hold_core_rst", core0, 1);
        chk("hold_counts", {cyc0, ret0, done0}, 0);
      end
      if (mode == 5 && n == h + 2) begin
        // Mid-DRAIN, between edges.
        #2 rst = 1'b1;
        #1;
        chk_reset_vals("async_rst");
        break;
      end
    end
    wb_valid = 1'b0;
    if (mode != 5) begin
      chk("final_core_rst", core0, 0);
      chk("final_done", done0, m0.fin);
      chk("final_pass", pass0, m0.p);
      chk("final_timeout", tmo0, m0.t);
      chk("final_stall", stall0, m0.s);
      chk("final_cycle_count", cyc0, m0.cyc);
      chk("final_retired_count", ret0, m0.ret);
      chk("final_sat_done", done1, m1.fin);
      chk("final_sat_flags", {pass1, tmo1, stall1}, {m1.p, m1.t, m1.s});
      chk("final_sat_cycle_count", cyc1, m1.cyc);
      chk("final_sat_retired_count", ret1, m1.ret);
    end
    chk("events_left_main", q0.size(), 0);
    chk("events_left_sat", q1.size(), 0);
    q0.delete();
    q1.delete();
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        mon(0, core0, done0, pass0, tmo0, stall0, longint'(cyc0), longint'(ret0));
        mon(1, core1, done1, pass1, tmo1, stall1, longint'(cyc1), longint'(ret1));
      end
    join_none
    run(0, 20);
    run(4, 0);
    run(3, 100);
    run(2, 0);
    run(5, 15);
    for (int k = 0; k < 6; k++) run(1, $urandom_range(5, 90));
    for (int k = 0; k < 2; k++) run(2, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
